// File: rtl/cluster_unpacker1536_if.sv
// Cluster set in / rebuilt strip map out for cluster_unpacker1536.
interface cluster_unpacker1536_if;
  logic          load;
  logic [87:0]   adr_in;
  logic [23:0]   cnt_in;
  logic [1535:0] vpfs_out;
  logic          valid_out;
  logic          busy;
  logic [2:0]    pass;
  logic          dropped;

  // Producer of cluster sets, consumer of the rebuilt map.
  modport master (
    output load, adr_in, cnt_in,
    input  vpfs_out, valid_out, busy, pass, dropped
  );

  // The unpacker itself.
  modport slave (
    input  load, adr_in, cnt_in,
    output vpfs_out, valid_out, busy, pass, dropped
  );
endinterface

// File: rtl/cluster_unpacker1536.sv
// Rebuilds a 1536-strip hit map from a set of 8 packed clusters (11-bit address,
// 3-bit size-1). One cluster is ORed into the accumulator per clock4x cycle; the
// finished map is registered and held until the next set completes.
module cluster_unpacker1536 (
  input logic                    clock4x,
  input logic                    reset,
  cluster_unpacker1536_if.slave  bus
);

  localparam int unsigned MXSBITS    = 1536;
  localparam int unsigned MXADRBITS  = 11;
  localparam int unsigned MXCNTBITS  = 3;
  localparam int unsigned MXCLUSTERS = 8;

  typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

  state_e                            state_q;
  logic [MXCLUSTERS*MXADRBITS-1:0]   adr_q;
  logic [MXCLUSTERS*MXCNTBITS-1:0]   cnt_q;
  logic [MXSBITS-1:0]                acc_q;
  logic [MXSBITS-1:0]                vpfs_q;
  logic                              valid_q;
  logic                              busy_q;
  logic [2:0]                        pass_q;
  logic                              dropped_q;

  logic [MXADRBITS-1:0]              adr_sel;
  logic [MXCNTBITS-1:0]              cnt_sel;
  logic [MXCNTBITS+5:0]              seg;
  logic [MXSBITS-1:0]                mask;

  // Strip mask of the cluster selected by the current pass. Bits shifted past
  // the top strip fall off the 1536-bit result, which gives the clip (no wrap).
  always_comb begin
    adr_sel = adr_q[int'(pass_q)*MXADRBITS +: MXADRBITS];
    cnt_sel = cnt_q[int'(pass_q)*MXCNTBITS +: MXCNTBITS];
    seg     = (9'd1 << ({1'b0, cnt_sel} + 4'd1)) - 9'd1;
    mask    = '0;
    // Out-of-range addresses, including the 0x7FF empty code, contribute nothing.
    if (adr_sel < 11'd1536) begin
      mask = {{(MXSBITS-9){1'b0}}, seg} << adr_sel;
    end
  end

  // Control FSM with registered outputs; reset wins over load.
  always_ff @(posedge clock4x) begin
    if (reset) begin
      state_q   <= StIdle;
      adr_q     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      vpfs_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      pass_q    <= 3'd0;
      dropped_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.load) begin
            state_q <= StExpand;
            adr_q   <= bus.adr_in;
            cnt_q   <= bus.cnt_in;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            pass_q  <= 3'd0;
          end else begin
            state_q <= StIdle;
          end
        end
        StExpand: begin
          // A set is already in flight; a new one is discarded and flagged.
          if (bus.load) begin
            dropped_q <= 1'b1;
          end
          acc_q <= acc_q | mask;
          if (pass_q == 3'd7) begin
            state_q <= StDone;
            vpfs_q  <= acc_q | mask;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= 3'd0;
          end else begin
            pass_q <= pass_q + 3'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          pass_q  <= 3'd0;
        end
      endcase
    end
  end

  assign bus.vpfs_out  = vpfs_q;
  assign bus.valid_out = valid_q;
  assign bus.busy      = busy_q;
  assign bus.pass      = pass_q;
  assign bus.dropped   = dropped_q;

endmodule

// File: tb/tb_cluster_unpacker1536.sv
// Directed and random checks of cluster_unpacker1536 against hand-computed maps
// and an independent strip-by-strip expansion model.
module tb_cluster_unpacker1536;

  logic clock4x = 1'b0;
  logic reset   = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  cluster_unpacker1536_if bus ();

  cluster_unpacker1536 dut (
    .clock4x (clock4x),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clock4x = ~clock4x;

  // Outputs are sampled and inputs driven 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock4x);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_map(input string tag, input logic [1535:0] obs, input logic [1535:0] exp);
    int first;
    first = -1;
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      for (int i = 1535; i >= 0; i--) if (obs[i] !== exp[i]) first = i;
      $error("FAIL %s: map differs first at bit %0d, got %0d set bits expected %0d",
             tag, first, $countones(obs), $countones(exp));
    end
  endtask

  // Independent model: walk each strip of each cluster, skip anything off the map.
  function automatic logic [1535:0] model(input logic [87:0] a, input logic [23:0] c);
    logic [1535:0] m;
    int ad;
    int n;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      ad = int'(a[11*i +: 11]);
      n  = int'(c[3*i +: 3]);
      for (int j = 0; j <= n; j++) if (ad + j < 1536) m[ad+j] = 1'b1;
    end
    return m;
  endfunction

  // Load one set in the current cycle, expect valid_out exactly 9 cycles later.
  task automatic run_set(input string tag, input logic [87:0] a, input logic [23:0] c,
                         input logic [1535:0] exp);
    int lat;
    bus.load   = 1'b1;
    bus.adr_in = a;
    bus.cnt_in = c;
    tick();
    bus.load = 1'b0;
    chk({tag, " busy after load"}, 32'(bus.busy), 32'd1);
    chk({tag, " pass after load"}, 32'(bus.pass), 32'd0);
    lat = 0;
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (bus.valid_out === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'd9);
    chk_map({tag, " map"}, bus.vpfs_out, exp);
    chk({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    tick();
    chk({tag, " valid one cycle"}, 32'(bus.valid_out), 32'd0);
    chk_map({tag, " map held"}, bus.vpfs_out, exp);
  endtask

  logic [87:0]   empty_adr;
  logic [87:0]   a;
  logic [87:0]   adr_a;
  logic [87:0]   adr_c;
  logic [23:0]   c;
  logic [1535:0] exp;
  logic [1535:0] exp_a;
  logic [1535:0] exp_c;

  initial begin
    bus.load   = 1'b1;
    bus.adr_in = '0;
    bus.cnt_in = '0;
    empty_adr  = {8{11'h7FF}};

    // Reset with load held high: reset wins.
    tick();
    tick();
    reset    = 1'b0;
    bus.load = 1'b0;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset pass", 32'(bus.pass), 32'd0);
    chk("reset valid", 32'(bus.valid_out), 32'd0);
    chk("reset dropped", 32'(bus.dropped), 32'd0);
    chk_map("reset map", bus.vpfs_out, '0);
    tick();
    chk("idle after reset", 32'(bus.busy), 32'd0);

    // Single cluster at 5, size 3.
    a = empty_adr;
    a[10:0] = 11'd5;
    c = '0;
    c[2:0] = 3'd2;
    exp = '0;
    exp[5] = 1'b1; exp[6] = 1'b1; exp[7] = 1'b1;
    run_set("t1", a, c, exp);

    // All empty code, then all beyond the map.
    run_set("t2a", empty_adr, 24'hFFFFFF, '0);
    run_set("t2b", {8{11'd1600}}, 24'hFFFFFF, '0);

    // Clip at the top strip, no wrap to bit 0/1.
    a = empty_adr;
    a[10:0]  = 11'd1534;
    a[21:11] = 11'd0;
    c = '0;
    c[2:0] = 3'd7;
    exp = '0;
    exp[0] = 1'b1; exp[1534] = 1'b1; exp[1535] = 1'b1;
    run_set("t3", a, c, exp);

    // Overlap, duplicate and a cluster spanning 767/768.
    a = empty_adr;
    a[10:0] = 11'd10;  a[21:11] = 11'd12; a[32:22] = 11'd767; a[43:33] = 11'd10;
    c = '0;
    c[2:0] = 3'd3; c[5:3] = 3'd3; c[8:6] = 3'd1; c[11:9] = 3'd3;
    exp = '0;
    for (int i = 10; i <= 15; i++) exp[i] = 1'b1;
    exp[767] = 1'b1; exp[768] = 1'b1;
    run_set("t4", a, c, exp);

    // Load in EXPAND is dropped; load in DONE is accepted back to back.
    adr_a = empty_adr;
    adr_a[10:0] = 11'd100;
    exp_a = '0;
    exp_a[100] = 1'b1;
    adr_c = empty_adr;
    adr_c[87:77] = 11'd200;
    exp_c = '0;
    exp_c[200] = 1'b1; exp_c[201] = 1'b1;
    bus.load = 1'b1; bus.adr_in = adr_a; bus.cnt_in = '0;
    tick();                                         // A+1
    bus.load = 1'b0;
    tick(); tick(); tick();                         // A+4
    bus.load = 1'b1; bus.adr_in = {8{11'd300}}; bus.cnt_in = 24'hFFFFFF;
    tick();                                         // A+5
    bus.load = 1'b0;
    chk("t5 dropped pulse", 32'(bus.dropped), 32'd1);
    chk("t5 pass kept", 32'(bus.pass), 32'd4);
    tick();                                         // A+6
    chk("t5 dropped one cycle", 32'(bus.dropped), 32'd0);
    tick(); tick();                                 // A+8
    chk("t5 pass 7", 32'(bus.pass), 32'd7);
    chk("t5 not valid yet", 32'(bus.valid_out), 32'd0);
    tick();                                         // A+9
    chk("t5 valid A", 32'(bus.valid_out), 32'd1);
    chk_map("t5 map A", bus.vpfs_out, exp_a);
    bus.load = 1'b1; bus.adr_in = adr_c; bus.cnt_in = 24'o10000000;
    tick();                                         // A+10
    bus.load = 1'b0;
    chk("t5 busy C", 32'(bus.busy), 32'd1);
    chk_map("t5 map A held", bus.vpfs_out, exp_a);
    for (int k = 0; k < 7; k++) tick();             // A+17
    chk("t5 C not early", 32'(bus.valid_out), 32'd0);
    tick();                                         // A+18
    chk("t5 valid C", 32'(bus.valid_out), 32'd1);
    chk_map("t5 map C", bus.vpfs_out, exp_c);
    tick();

    // Reset mid-expansion discards the set.
    bus.load = 1'b1; bus.adr_in = adr_a; bus.cnt_in = '0;
    tick();                                         // A+1
    bus.load = 1'b0;
    for (int k = 0; k < 4; k++) tick();             // A+5
    reset = 1'b1;
    tick();                                         // A+6
    reset = 1'b0;
    chk("t6 busy", 32'(bus.busy), 32'd0);
    chk("t6 pass", 32'(bus.pass), 32'd0);
    chk("t6 valid", 32'(bus.valid_out), 32'd0);
    chk_map("t6 map cleared", bus.vpfs_out, '0);
    for (int k = 0; k < 5; k++) tick();
    chk("t6 no late valid", 32'(bus.valid_out), 32'd0);
    run_set("t6 fresh", adr_c, 24'o10000000, exp_c);

    // Random sets against the reference model.
    for (int s = 0; s < 200; s++) begin
      for (int i = 0; i < 8; i++) begin
        a[11*i +: 11] = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(1500, 2047))
                                                    : 11'($urandom_range(0, 1535));
        c[3*i +: 3]   = 3'($urandom_range(0, 7));
      end
      run_set("rand", a, c, model(a, c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
